// File: rtl/seq_datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_datapath_pkg
//  Description : Shared types and constants for the sequential datapath:
//                default WIDTH/NREGS, ALU opcode enum and FSM state enum.
//                Optional feature macro used by the datapath:
//                SEQ_DATAPATH_FLAGS_EN (adds the {C, N, Zf} flags output).
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_datapath_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREGS = 16;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2,
    ST_T3   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/seq_datapath_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_datapath_alu
//  Description : Purely combinational ALU for the sequential datapath.
//  Ports       : a      - first operand (Y register)
//                b      - second operand (internal bus in T2)
//                op     - operation code
//                result - op(a, b), modulo 2^WIDTH
//                carry  - carry-out for ADD, carry-out of a + ~b + 1 for SUB,
//                         0 for every other op
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_datapath_alu
  import seq_datapath_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;
  logic [SW-1:0]  w_shamt;

  // Subtraction as a + ~b + 1 so the top bit is the "no borrow" carry.
  assign w_sum   = {1'b0, a} + {1'b0, b};
  assign w_diff  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  // Only the low clog2(WIDTH) bits of b select the shift distance.
  assign w_shamt = b[SW-1:0];

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD:  begin result = w_sum[WIDTH-1:0];  carry = w_sum[WIDTH];  end
      OP_SUB:  begin result = w_diff[WIDTH-1:0]; carry = w_diff[WIDTH]; end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << w_shamt;
      OP_SHR:  result = a >> w_shamt;
      OP_PASS: result = b;
      default: result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seq_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : seq_datapath
//  Description : Single-bus sequential datapath. A register file, Y and Z
//                latches and an ALU share one internal bus, sequenced by a
//                four-state FSM (IDLE, T1, T2, T3):
//                  T1: bus = R[src_a], Y <= bus
//                  T2: bus = R[src_b], Z <= ALU(Y, bus, op)
//                  T3: bus = Z,        R[dst] <= bus
//                Optional macro SEQ_DATAPATH_FLAGS_EN adds flags[2:0] =
//                {C, N, Zf}, captured together with Z in T2.
//  Ports       : clock, clear (sync active-high reset)
//                start, op, src_a, src_b, dst - operation request (IDLE only)
//                ld_en, ld_addr, ld_data      - external write (IDLE only)
//                rd_addr / rd_data            - combinational register read
//                busy (T1..T3), done (1-cycle pulse after write), bus_out
//                flags (only with SEQ_DATAPATH_FLAGS_EN)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_datapath
  import seq_datapath_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREGS = DEF_NREGS,
  localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  input  logic [AW-1:0]    dst,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] bus_out
`ifdef SEQ_DATAPATH_FLAGS_EN
  ,
  output logic [2:0]       flags
`endif
);

  state_e           state_q;
  op_e              op_q;
  logic [AW-1:0]    src_a_q;
  logic [AW-1:0]    src_b_q;
  logic [AW-1:0]    dst_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] z_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] regs_q [NREGS];

  logic [WIDTH-1:0] w_bus;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_carry;

  // Internal bus source follows the current micro-step; idle bus reads 0.
  always_comb begin
    w_bus = '0;
    case (state_q)
      ST_T1:   w_bus = regs_q[src_a_q];
      ST_T2:   w_bus = regs_q[src_b_q];
      ST_T3:   w_bus = z_q;
      default: w_bus = '0;
    endcase
  end

  seq_datapath_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a      (y_q),
    .b      (w_bus),
    .op     (op_q),
    .result (w_alu_res),
    .carry  (w_alu_carry)
  );

  // FSM, operand latches and Y/Z. busy/done are registered so they line up
  // with the state they describe.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      y_q     <= '0;
      z_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_T1;
            busy_q  <= 1'b1;
            op_q    <= op_e'(op);
            src_a_q <= src_a;
            src_b_q <= src_b;
            dst_q   <= dst;
          end
        end
        ST_T1: begin
          state_q <= ST_T2;
          y_q     <= w_bus;
        end
        ST_T2: begin
          state_q <= ST_T3;
          z_q     <= w_alu_res;
        end
        ST_T3: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Register file. An external load and a start in the same IDLE cycle both
  // take effect, so T1 reads the freshly loaded value.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if ((state_q == ST_IDLE) && ld_en) begin
      regs_q[ld_addr] <= ld_data;
    end else if (state_q == ST_T3) begin
      regs_q[dst_q] <= w_bus;
    end
  end

`ifdef SEQ_DATAPATH_FLAGS_EN
  logic [2:0] flags_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      flags_q <= '0;
    end else if (state_q == ST_T2) begin
      flags_q <= {w_alu_carry, w_alu_res[WIDTH-1], (w_alu_res == '0)};
    end
  end

  assign flags = flags_q;
`else
  logic w_carry_unused;
  assign w_carry_unused = w_alu_carry;
`endif

  assign rd_data = regs_q[rd_addr];
  assign busy    = busy_q;
  assign done    = done_q;
  assign bus_out = w_bus;

endmodule
`default_nettype wire

// File: tb/tb_seq_datapath.sv
`timescale 1ns/1ps
module tb_seq_datapath;
  import seq_datapath_pkg::*;

  localparam int WIDTH = 32;
  localparam int NREGS = 16;
  localparam int AW    = 4;

  logic             clock = 1'b0;
  logic             clear;
  logic             start;
  logic [2:0]       op;
  logic [AW-1:0]    src_a, src_b, dst;
  logic             ld_en;
  logic [AW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             busy, done;
  logic [WIDTH-1:0] bus_out;
`ifdef SEQ_DATAPATH_FLAGS_EN
  logic [2:0]       flags;
`endif

  always #5 clock = ~clock;

  seq_datapath #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clock   (clock),
    .clear   (clear),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .dst     (dst),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .bus_out (bus_out)
`ifdef SEQ_DATAPATH_FLAGS_EN
    ,
    .flags   (flags)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [AW-1:0]    dst;
    logic [WIDTH-1:0] val;
    logic [2:0]       flg;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] mdl [NREGS];

  // Reference behaviour of one operation: result plus {C, N, Zf}.
  function automatic exp_t model(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic [AW-1:0] d);
    exp_t e;
    logic [WIDTH-1:0] r;
    logic c;
    c = 1'b0;
    r = '0;
    case (o)
      3'b000: {c, r} = a + b;
      3'b001: begin r = a - b; c = (a >= b); end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: r = a << b[4:0];
      3'b110: r = a >> b[4:0];
      default: r = b;
    endcase
    e.dst = d;
    e.val = r;
    e.flg = {c, r[WIDTH-1], (r == '0)};
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
    mdl[a] = d;
  endtask

  // Issue one op, push its expected result, then scramble the request inputs
  // so a DUT that fails to latch them produces a wrong answer.
  task automatic start_op(input logic [2:0] o, input logic [AW-1:0] a,
                          input logic [AW-1:0] b, input logic [AW-1:0] d);
    op = o; src_a = a; src_b = b; dst = d; start = 1'b1;
    sb.push_back(model(o, mdl[a], mdl[b], d));
    tick();
    start = 1'b0; ld_en = 1'b0;
    op    = 3'($urandom_range(7));
    src_a = AW'($urandom_range(15));
    src_b = AW'($urandom_range(15));
    dst   = AW'($urandom_range(15));
  endtask

  // Bounded wait for done; reports cycles after the start edge and busy count.
  task automatic wait_done(output int cyc, output int bc, output bit ok);
    cyc = 0; bc = 0; ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (busy) bc++;
      if (done) begin ok = 1'b1; break; end
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    tick(); tick();
    clear = 1'b0;
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: busy=%b done=%b, required 0 0", busy, done);
    end
    n_tests++;
    if (bus_out !== '0) begin
      n_fail++; $display("FAIL reset_bus: got %h required 0", bus_out);
    end
    for (int i = 0; i < NREGS; i++) begin
      rd_addr = AW'(i); #1;
      n_tests++;
      if (rd_data !== '0) begin
        n_fail++; $display("FAIL reset_reg R%0d: got %h required 0", i, rd_data);
      end
    end
`ifdef SEQ_DATAPATH_FLAGS_EN
    n_tests++;
    if (flags !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b required 000", flags);
    end
`endif
  endtask

  task automatic test_add();
    int cyc, bc; bit ok; exp_t e;
    load(1, 5); load(2, 7);
    start_op(3'b000, 1, 2, 3);
    n_tests++;
    if (bus_out !== 32'd5) begin
      n_fail++; $display("FAIL add_bus_t1: got %h required 5", bus_out);
    end
    wait_done(cyc, bc, ok);
    n_tests++;
    if (!ok || cyc != 3 || bc != 3) begin
      n_fail++; $display("FAIL add_timing: done=%0d cycles=%0d busy=%0d, required 1/3/3", ok, cyc, bc);
    end
    e = sb.pop_front();
    rd_addr = e.dst; #1;
    n_tests++;
    if (rd_data !== e.val || rd_data !== 32'd12) begin
      n_fail++; $display("FAIL add_result R3: got %h required %h", rd_data, e.val);
    end
    mdl[e.dst] = e.val;
    tick();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL add_done_pulse: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_ops();
    int cyc, bc; bit ok; exp_t e;
    logic [2:0] o;
    logic [WIDTH-1:0] va, vb;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin
        o = 3'(i); va = $urandom; vb = $urandom;
      end else if (i == 8) begin
        o = 3'b001; va = 32'd3; vb = 32'd5;
      end else if (i == 9) begin
        o = 3'b101; va = 32'd1; vb = 32'd35;
      end else begin
        o = 3'b000; va = 32'hFFFF_FFFF; vb = 32'd1;
      end
      load(1, va); load(2, vb);
      start_op(o, 1, 2, AW'(i + 3));
      wait_done(cyc, bc, ok);
      n_tests++;
      if (!ok) begin
        n_fail++; $display("FAIL ops_done case %0d: no done within bound", i);
        sb.delete();
        continue;
      end
      e = sb.pop_front();
      rd_addr = e.dst; #1;
      n_tests++;
      if (rd_data !== e.val) begin
        n_fail++; $display("FAIL ops_result case %0d op %0d: got %h required %h", i, o, rd_data, e.val);
      end
`ifdef SEQ_DATAPATH_FLAGS_EN
      n_tests++;
      if (flags !== e.flg) begin
        n_fail++; $display("FAIL ops_flags case %0d op %0d: got %b required %b", i, o, flags, e.flg);
      end
`endif
      mdl[e.dst] = e.val;
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc; bit ok; exp_t e;
    load(1, 2); load(2, 3);
    op = 3'b000; src_a = 1; src_b = 2; dst = 7; start = 1'b1;
    sb.push_back(model(3'b000, mdl[1], mdl[2], 7));
    tick();                                  // now T1, start still high
    dst = 8;
    sb.push_back(model(3'b000, mdl[1], mdl[2], 8));
    tick();                                  // T2: attempt an ignored load
    ld_en = 1'b1; ld_addr = 1; ld_data = 32'd99;
    tick();                                  // T3
    ld_en = 1'b0;
    tick();                                  // done cycle
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first_done: done=%b busy=%b, required 1 0", done, busy);
    end
    e = sb.pop_front();
    rd_addr = e.dst; #1;
    n_tests++;
    if (rd_data !== e.val) begin
      n_fail++; $display("FAIL b2b_first_result: got %h required %h", rd_data, e.val);
    end
    mdl[e.dst] = e.val;
    tick();                                  // second op accepted at done edge
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second_start: busy=%b, required 1", busy);
    end
    wait_done(cyc, bc, ok);
    n_tests++;
    if (!ok || cyc != 3) begin
      n_fail++; $display("FAIL b2b_second_timing: done=%0d cycles=%0d, required 1/3", ok, cyc);
    end
    e = sb.pop_front();
    rd_addr = e.dst; #1;
    n_tests++;
    if (rd_data !== e.val) begin
      n_fail++; $display("FAIL b2b_second_result: got %h required %h", rd_data, e.val);
    end
    mdl[e.dst] = e.val;
    rd_addr = 1; #1;
    n_tests++;
    if (rd_data !== 32'd2) begin
      n_fail++; $display("FAIL b2b_ignored_load R1: got %h required 2", rd_data);
    end
  endtask

  task automatic test_load_start_same();
    int cyc, bc; bit ok; exp_t e;
    ld_en = 1'b1; ld_addr = 1; ld_data = 32'd10;
    mdl[1] = 32'd10;
    start_op(3'b000, 1, 1, 1);
    wait_done(cyc, bc, ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL ldstart_done: no done within bound");
      sb.delete();
    end else begin
      e = sb.pop_front();
      rd_addr = e.dst; #1;
      n_tests++;
      if (rd_data !== e.val || rd_data !== 32'd20) begin
        n_fail++; $display("FAIL ldstart_result R1: got %h required %h", rd_data, e.val);
      end
      mdl[e.dst] = e.val;
    end
  endtask

  task automatic test_clear();
    bit seen;
    load(6, 9); load(1, 4); load(2, 4);
    start_op(3'b000, 1, 2, 6);
    tick();                                  // T2
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sb.delete();
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL clear_abort_ctrl: busy=%b done=%b, required 0 0", busy, done);
    end
    rd_addr = 6; #1;
    n_tests++;
    if (rd_data !== '0) begin
      n_fail++; $display("FAIL clear_abort R6: got %h required 0", rd_data);
    end
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (done) seen = 1'b1;
      tick();
    end
    n_tests++;
    if (seen) begin
      n_fail++; $display("FAIL clear_no_done: done=1 seen, required 0");
    end
    // clear outranks a simultaneous start and load
    clear = 1'b1; start = 1'b1; op = 3'b000; src_a = 1; src_b = 1; dst = 2;
    ld_en = 1'b1; ld_addr = 1; ld_data = 32'd55;
    tick();
    clear = 1'b0; start = 1'b0; ld_en = 1'b0;
    rd_addr = 1; #1;
    n_tests++;
    if (busy !== 1'b0 || rd_data !== '0) begin
      n_fail++; $display("FAIL clear_priority: busy=%b R1=%h, required 0 0", busy, rd_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; dst = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    test_reset();
    test_add();
    test_ops();
    test_back_to_back();
    test_load_start_same();
    test_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_datapath.md
SEQ_DATAPATH -- requirements
Module: seq_datapath

Interface
REQ-001 Parameter WIDTH, default 32, data width of bus and all registers.
REQ-002 Parameter NREGS, default 16, number of general registers; address width AW = clog2(NREGS).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 clear  input  1  reset; one clock, reset synchronous, active-high.
REQ-005 start  input  1  request one operation; sampled only in IDLE.
REQ-006 op  input  3  operation code, captured with start.
REQ-007 src_a, src_b, dst  input  AW each  operand/destination register addresses, captured with start.
REQ-008 ld_en  input  1  external register write strobe; honoured only in IDLE.
REQ-009 ld_addr  input  AW; ld_data  input  WIDTH  external write address/data.
REQ-010 rd_addr  input  AW; rd_data  output  WIDTH  combinational read of R[rd_addr].
REQ-011 busy  output  1  high in T1..T3.
REQ-012 done  output  1  one-cycle pulse after result write.
REQ-013 bus_out  output  WIDTH  current internal bus value, for debug.

Function
REQ-014 FSM states IDLE, T1, T2, T3; IDLE->T1 on start, T1->T2->T3->IDLE unconditionally.
REQ-015 T1: bus = R[src_a]; Y <= bus.
REQ-016 T2: bus = R[src_b]; Z <= ALU(Y, bus, op).
REQ-017 T3: bus = Z; R[dst] <= bus.
REQ-018 In IDLE bus = 0.
REQ-019 done high for exactly the cycle after T3; R[dst] new value readable on rd_data in that cycle; total start-to-done latency 4 cycles.
REQ-020 start while busy is ignored; start in the done cycle (state IDLE) is accepted, back-to-back throughput one op per 4 cycles.
REQ-021 op/src_a/src_b/dst latched on start acceptance; later input changes have no effect on the running op.
REQ-022 ld_en while busy is ignored, no register changes.
REQ-023 ld_en and start in the same IDLE cycle: load written at that edge, op accepted; T1 reads the loaded value.
REQ-024 Opcodes: 000 ADD, 001 SUB (Y-B), 010 AND, 011 OR, 100 XOR, 101 SHL Y by B[clog2(WIDTH)-1:0], 110 SHR logical same amount, 111 PASS B.
REQ-025 Arithmetic modulo 2^WIDTH; no saturation; shift amounts use only the low clog2(WIDTH) bits.
REQ-026 src_a = src_b = dst permitted; reads in T1/T2 see pre-write values.

Reset
REQ-027 clear high at an edge: state IDLE, all R[i], Y, Z = 0, busy = 0, done = 0, flags = 0.
REQ-028 clear mid-operation aborts; no write to R[dst]; no done pulse.
REQ-029 clear has priority over start and ld_en in the same cycle.

Configuration
REQ-030 Macro SEQ_DATAPATH_FLAGS_EN defined: extra output flags[2:0] = {C, N, Zf}, registered with Z in T2, held otherwise.
REQ-031 Zf = (result == 0); N = result[WIDTH-1]; C = carry-out for ADD, carry-out of Y + ~B + 1 for SUB, 0 for other ops.
REQ-032 Macro undefined: no flags port, no flag logic.

Structure
REQ-033 Package seq_datapath_pkg holds opcode enum, FSM state enum, default WIDTH/NREGS constants.
REQ-034 ALU is a separate combinational sub-module seq_datapath_alu (ports a, b, op, result, carry).
REQ-035 Register file, Y, Z, FSM and bus mux reside in seq_datapath.

Verification
REQ-036 Load R1=5, R2=7; start ADD src_a=1 src_b=2 dst=3 -> done 4 cycles later, R3=12, busy high exactly 3 cycles.
REQ-037 R1=3, R2=5, SUB dst=4 -> R4=0xFFFFFFFE; with FLAGS_EN flags: N=1, Zf=0, C=0.
REQ-038 R1=0x1, R2=35, SHL dst=5 -> R5=0x8 (shift amount 3); R1=0xFFFFFFFF, R2=1, ADD -> 0, with FLAGS_EN Zf=1, C=1.
REQ-039 start held high plus ld_en to R1 during T2 -> second op starts only at done cycle; R1 unchanged by ignored load.
REQ-040 clear asserted in T2 of ADD to dst=6 with R6=9 -> next cycle state IDLE, R6=0, no done pulse.
REQ-041 ld_en R1=10 and start ADD src_a=1 src_b=1 dst=1 same cycle -> R1=20 at done.
